// File: rtl/pipe_hazard_if.sv
// rtl/pipe_hazard_if.sv - hazard information in, pipeline register controls out
// master: pipeline side; slave: pipe_hazard_ctrl.
interface pipe_hazard_if #(
  parameter int ASIZE  = 5,
  parameter int CWIDTH = 16
);
  logic [ASIZE-1:0]  id_rs1;
  logic [ASIZE-1:0]  id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_memRead;
  logic              ex_wen;
  logic [ASIZE-1:0]  ex_waddr;
  logic              ex_redirect;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_flush;
  logic              exmem_en;
  logic              mem_err;
  logic [1:0]        state;
  logic [CWIDTH-1:0] stall_cnt;
  logic [CWIDTH-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_wen, ex_waddr,
           ex_redirect, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_err,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_wen, ex_waddr,
           ex_redirect, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_err,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline sequencer: load-use, redirect, memory wait
// Enables/flushes are combinational; state, watchdog and performance counters are registered.
module pipe_hazard_ctrl #(
  parameter int ASIZE   = 5,
  parameter int TIMEOUT = 15,
  parameter int CWIDTH  = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  localparam logic [7:0]        TO_LIM  = 8'(TIMEOUT);
  localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

  state_t            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              err_q, err_d;
  logic [CWIDTH-1:0] stall_q, stall_d;
  logic [CWIDTH-1:0] flush_q, flush_d;

  logic load_use, mem_stall, apply_run;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;

  assign load_use  = bus.ex_memRead & bus.ex_wen & (bus.ex_waddr != '0) &
                     ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_waddr)) |
                      (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_waddr)));
  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    stall_d = stall_q;
    flush_d = flush_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_WAIT;
          wait_d  = 8'd1;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_d >= TO_LIM) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_ERR: err_d = 1'b1;
      default: state_d = ST_RUN;
    endcase
    // Counters saturate rather than wrap so long runs stay meaningful.
    if (!pc_en && stall_q != CNT_MAX) stall_d = stall_q + CWIDTH'(1);
    if (ifid_flush && flush_q != CNT_MAX) flush_d = flush_q + CWIDTH'(1);
  end

  // The exit cycle of MEM_WAIT applies any held redirect/load-use immediately.
  assign apply_run = ((state_q == ST_RUN) && !mem_stall) ||
                     ((state_q == ST_WAIT) && bus.mem_ready);

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    if (rst && apply_run) begin
      if (bus.ex_redirect) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else if (load_use) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_en    = idex_en;
  assign bus.idex_flush = idex_flush;
  assign bus.exmem_en   = exmem_en;
  assign bus.mem_err    = err_q;
  assign bus.state      = state_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It drives the enable and flush controls of the PC, IF/ID, ID/EXE and EXE/MEM registers. It handles four conditions: load-use stalls, branch/jal redirect flushes, multi-cycle data-memory waits with a watchdog, and stall/flush performance counting. It sits beside the pipeline registers and takes hazard information from the ID and EXE stages plus the data-memory handshake.

Parameters:
ASIZE, 5, register address width; address 0 is the hardwired zero register.
TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before error (1..255).
CWIDTH, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
id_rs1  in  ASIZE  source reg 1 of instruction in ID
id_rs2  in  ASIZE  source reg 2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_memRead  in  1  EXE instruction is a load
ex_wen  in  1  EXE instruction writes a register
ex_waddr  in  ASIZE  EXE destination register
ex_redirect  in  1  EXE branch taken or jal; PC target valid this cycle
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads bubble (all control zero)
idex_en  out  1  ID/EXE load enable
idex_flush  out  1  ID/EXE loads bubble
exmem_en  out  1  EXE/MEM load enable
mem_err  out  1  sticky watchdog error
state  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 ERROR
stall_cnt  out  CWIDTH  saturating count of cycles with pc_en=0
flush_cnt  out  CWIDTH  saturating count of redirects applied

Behaviour:
- Reset (rst=0, async): state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. While rst=0, all enables=0 and both flushes=0 (forced).
- Enables and flushes are combinational from state and the current inputs. State and counters are registered.
- load_use = ex_memRead & ex_wen & (ex_waddr!=0) & ((id_use_rs1 & id_rs1==ex_waddr) | (id_use_rs2 & id_rs2==ex_waddr)).
- mem_stall = mem_req & ~mem_ready.
- RUN, with conditions checked in priority order:
  1. mem_stall: all four enables 0, flushes 0; next MEM_WAIT, wait counter <= 1.
  2. ex_redirect: all enables 1, ifid_flush=1, idex_flush=1; flush_cnt++. Redirect overrides load_use because the dependent instruction is squashed.
  3. load_use: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1 (bubble), exmem_en=1. This is a one-cycle stall; the condition clears naturally once the load advances.
  4. Otherwise: all enables 1, flushes 0.
- MEM_WAIT: all enables 0, flushes 0 (full freeze, EXE contents held).
  - mem_ready=1: next RUN. Outputs this cycle follow the RUN rules with mem_stall treated as 0, so a held redirect or load_use is applied in the same cycle.
  - Otherwise: wait counter++. If the counter reaches TIMEOUT, next ERROR and mem_err <= 1.
- ERROR: all enables 0, flushes 0, mem_err=1. Exit only through reset.
- stall_cnt increments on every non-reset cycle with pc_en=0, including in ERROR. flush_cnt increments on every applied redirect. Both saturate at all-ones and never wrap.
- A redirect arriving during MEM_WAIT is not lost: the frozen EXE stage keeps ex_redirect asserted until the exit cycle.
- Reset asserted mid-MEM_WAIT returns immediately to RUN with counters cleared.

Test Plan:
- Load-use: ex_memRead=1, ex_wen=1, ex_waddr=3, id_use_rs2=1, id_rs2=3 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt 0->1; next cycle with ex_memRead=0 -> all enables 1.
- Zero-register and no-use cases: ex_waddr=0 matching id_rs1, or id_use_rs1=0 with a matching rs1 -> no stall, stall_cnt unchanged.
- Redirect plus load_use in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> state=01 for 3 cycles with all enables 0; exit cycle all enables 1; stall_cnt=3.
- Watchdog: mem_req=1, mem_ready=0 held 20 cycles with TIMEOUT=15 -> state=10 and mem_err=1 after cycle 15 and remaining so; rst pulse low -> state=00, mem_err=0, counters 0.
- Redirect held during wait plus saturation: ex_redirect=1 throughout a 2-cycle MEM_WAIT -> flushes asserted only on the exit cycle, flush_cnt +1. With CWIDTH=4, 20 stall cycles -> stall_cnt holds at 15.
